// File: rtl/register_write_selector.sv
// rtl/register_write_selector.sv - multi-port register write arbiter with issue/write-back scoreboard
// Optional build macro REG_ZERO_PROTECT_EN makes register 0 unwritable and never pending.
module register_write_selector #(
   parameter int NUM_REGS   = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_PORTS  = 2
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_PORTS-1:0]            we_i,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0] waddr_i,
   input  logic                            issue_valid_i,
   input  logic [ADDR_WIDTH-1:0]           issue_addr_i,
   output logic [NUM_REGS-1:0]             select_o,
   output logic [NUM_PORTS-1:0]            grant_o,
   output logic                            conflict_o,
   output logic                            range_err_o,
   output logic [NUM_REGS-1:0]             pending_o
);

`ifdef REG_ZERO_PROTECT_EN
   localparam bit ZERO_PROTECT = 1'b1;
`else
   localparam bit ZERO_PROTECT = 1'b0;
`endif

   logic [ADDR_WIDTH-1:0] port_addr [NUM_PORTS];
   logic [NUM_PORTS-1:0]  eligible;
   logic [NUM_REGS-1:0]   issue_mask;

   logic [NUM_REGS-1:0]   select_d, select_q;
   logic [NUM_PORTS-1:0]  grant_d, grant_q;
   logic                  conflict_d, conflict_q;
   logic                  range_err_d, range_err_q;
   logic [NUM_REGS-1:0]   pending_d, pending_q;

   always_comb begin
      range_err_d = 1'b0;
      eligible    = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         port_addr[p] = waddr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
         if (we_i[p] && int'(port_addr[p]) >= NUM_REGS) begin
            range_err_d = 1'b1;
         end
         eligible[p] = we_i[p] && (int'(port_addr[p]) < NUM_REGS) &&
                       !(ZERO_PROTECT && port_addr[p] == '0);
      end
      if (issue_valid_i && int'(issue_addr_i) >= NUM_REGS) begin
         range_err_d = 1'b1;
      end

      // Lowest-indexed eligible port owns an address; later duplicates lose.
      grant_d = eligible;
      for (int p = 1; p < NUM_PORTS; p++) begin
         for (int q = 0; q < p; q++) begin
            if (eligible[q] && eligible[p] && port_addr[q] == port_addr[p]) begin
               grant_d[p] = 1'b0;
            end
         end
      end
      conflict_d = |(eligible & ~grant_d);

      select_d   = '0;
      issue_mask = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant_d[p] && int'(port_addr[p]) == r) begin
               select_d[r] = 1'b1;
            end
         end
         issue_mask[r] = issue_valid_i && (int'(issue_addr_i) == r) &&
                         !(ZERO_PROTECT && r == 0);
      end

      // A same-cycle issue re-arms the bit after the write-back clears it.
      pending_d = (pending_q & ~select_d) | issue_mask;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         select_q    <= '0;
         grant_q     <= '0;
         conflict_q  <= 1'b0;
         range_err_q <= 1'b0;
         pending_q   <= '0;
      end else begin
         select_q    <= select_d;
         grant_q     <= grant_d;
         conflict_q  <= conflict_d;
         range_err_q <= range_err_d;
         pending_q   <= pending_d;
      end
   end

   assign select_o    = select_q;
   assign grant_o     = grant_q;
   assign conflict_o  = conflict_q;
   assign range_err_o = range_err_q;
   assign pending_o   = pending_q;

endmodule

// File: doc/register_write_selector.md
REGISTER_WRITE_SELECTOR -- requirements
Module: register_write_selector

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, number of architectural registers (2..64).
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, register address width; ceil(log2(NUM_REGS)) <= ADDR_WIDTH.
REQ-003 SHALL have parameter NUM_PORTS, default 2, number of write ports (1..4).
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 SHALL have port: clk  input  1  rising-edge clock.
REQ-006 SHALL have port: reset  input  1  asynchronous active-low reset.
REQ-007 SHALL have port: we_i  input  NUM_PORTS  per-port write enable.
REQ-008 SHALL have port: waddr_i  input  NUM_PORTS*ADDR_WIDTH  port p address at bits [p*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 SHALL have port: issue_valid_i  input  1  instruction issued with a destination register.
REQ-010 SHALL have port: issue_addr_i  input  ADDR_WIDTH  destination register of issued instruction.
REQ-011 SHALL have port: select_o  output  NUM_REGS  registered one-hot-per-port register write selects.
REQ-012 SHALL have port: grant_o  output  NUM_PORTS  registered per-port write accepted.
REQ-013 SHALL have port: conflict_o  output  1  registered; two or more enabled ports targeted one register.
REQ-014 SHALL have port: range_err_o  output  1  registered; an enabled port or issue address >= NUM_REGS.
REQ-015 SHALL have port: pending_o  output  NUM_REGS  scoreboard; bit r = register r awaits write-back.

Function
REQ-016 Port p is eligible in cycle n when we_i[p]=1 and its address < NUM_REGS.
REQ-017 Eligible port p is granted unless a lower-indexed eligible port has the same address (lowest index wins).
REQ-018 select_o at cycle n+1 SHALL equal the OR over granted ports of (1 << address); all other bits 0; latency exactly 1 cycle.
REQ-019 grant_o[p] at cycle n+1 SHALL be 1 only for ports granted in cycle n.
REQ-020 conflict_o at cycle n+1 SHALL be 1 when any eligible port lost arbitration in cycle n, else 0.
REQ-021 range_err_o at cycle n+1 SHALL be 1 when any enabled port or a valid issue had address >= NUM_REGS; that request is dropped.
REQ-022 Scoreboard: pending bit r SHALL set on the clock after issue_valid_i=1 with issue_addr_i=r (in range).
REQ-023 Pending bit r SHALL clear on the clock after a port is granted a write to r.
REQ-024 Simultaneous issue to r and grant to r in the same cycle: pending bit r SHALL end set (new producer wins).
REQ-025 Grant to a register whose pending bit is 0 SHALL still write; pending stays 0.
REQ-026 With no eligible port, select_o, grant_o and conflict_o SHALL be 0 next cycle.

Reset
REQ-027 While reset=0, select_o, grant_o, conflict_o, range_err_o and pending_o SHALL be 0 immediately (asynchronous).
REQ-028 Requests presented while reset=0 SHALL be discarded; the first registered result reflects inputs at the first rising edge after reset deasserts.
REQ-029 Reset asserted mid-operation SHALL clear all pending bits; no partial state survives.

Configuration
REQ-030 Macro REG_ZERO_PROTECT_EN: when defined, address 0 SHALL never be eligible or issued: select_o[0] and pending_o[0] constant 0, no conflict/grant/range_err contribution from address 0.
REQ-031 Without REG_ZERO_PROTECT_EN, register 0 SHALL behave as any other register.

Verification
REQ-032 Defaults, we_i=2'b01, port0 addr 5 -> next cycle select_o=32'h0000_0020, grant_o=2'b01, conflict_o=0.
REQ-033 we_i=2'b11, both addr 9 -> select_o=32'h0000_0200, grant_o=2'b01, conflict_o=1; ports addr 3 and 31 -> select_o=32'h8000_0008, grant_o=2'b11.
REQ-034 Issue addr 7, later grant addr 7 -> pending_o[7] 1 then 0; issue addr 7 with grant addr 7 same cycle -> pending_o[7] stays 1.
REQ-035 NUM_REGS=24, port0 addr 30 enabled -> range_err_o=1, select_o=0, grant_o=0.
REQ-036 With REG_ZERO_PROTECT_EN, port0 addr 0 enabled and issue addr 0 -> select_o=0, grant_o=0, pending_o[0]=0; without macro -> select_o=32'h1.
REQ-037 Pending bits 4 and 12 set, reset pulsed low between edges -> all outputs 0 at once, pending_o=0 after release.
